// File: rtl/seq_count_timer_arb.sv
// -----------------------------------------------------------------------------
// seq_count_timer_arb
//
// Round-robin arbiter/sequencer sharing one external loadable down-counter
// among NREQ requesters. A granted requester's count value is loaded into the
// counter. The block then waits for the counter to reach zero and returns a
// one-cycle completion pulse to the requester that owns the counter.
//
// Ports:
//   clk       - clock, all state changes on posedge
//   reset_n   - asynchronous active-low reset
//   req_val   - [NREQ]   pending request per requester
//   req_cnt   - [NREQ*W] packed count values, requester i at [i*W +: W]
//   req_rdy   - [NREQ]   one-hot grant; accepted when req_val & req_rdy
//   resp_val  - [NREQ]   one-cycle completion pulse on the owner's bit
//   cnt_ld    - load strobe to the shared counter
//   cnt_in    - [W] load value to the shared counter
//   cnt_done  - shared counter is zero
//   busy      - a timeout is in progress (WAIT state)
//   owner     - index of the current owner while busy, 0 otherwise
// -----------------------------------------------------------------------------
module seq_count_timer_arb #(
    parameter int NREQ = 4,
    parameter int W    = 3,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_val,
    input  logic [NREQ*W-1:0]   req_cnt,
    output logic [NREQ-1:0]     req_rdy,
    output logic [NREQ-1:0]     resp_val,
    output logic                cnt_ld,
    output logic [W-1:0]        cnt_in,
    input  logic                cnt_done,
    output logic                busy,
    output logic [OW-1:0]       owner
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          fsm_reg;
    state_t          fsm_next;
    logic [OW-1:0]   owner_reg;
    logic [OW-1:0]   owner_next;
    logic [OW-1:0]   ptr_reg;
    logic [OW-1:0]   ptr_next;

    // Unpacked view of the per-requester count values.
    logic [W-1:0]    cnt_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign cnt_arr[gi] = req_cnt[gi*W +: W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search: first requester with req_val set, starting at ptr
    // and wrapping. The index is computed one bit wider so that ptr+k can be
    // reduced modulo NREQ for non-power-of-two requester counts.
    // -------------------------------------------------------------------------
    logic            gnt_found;
    logic [OW-1:0]   gnt_idx;
    logic [OW:0]     scan_idx;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_reg} + (OW+1)'(k);
            if (scan_idx >= (OW+1)'(NREQ)) begin
                scan_idx = scan_idx - (OW+1)'(NREQ);
            end
            if (!gnt_found && req_val[scan_idx[OW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[OW-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg   <= ST_IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fsm_next   = fsm_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (gnt_found) begin
                    fsm_next   = ST_WAIT;
                    owner_next = gnt_idx;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    fsm_next = ST_IDLE;
                    // Next search starts just after the requester that was
                    // served, so a continuously requesting owner yields.
                    ptr_next = (owner_reg == OW'(NREQ-1)) ? '0
                                                          : owner_reg + OW'(1);
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_rdy  = '0;
        resp_val = '0;
        cnt_ld   = 1'b0;
        cnt_in   = '0;
        busy     = 1'b0;
        owner    = '0;
        case (fsm_reg)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_rdy[gnt_idx] = 1'b1;
                    cnt_ld           = 1'b1;
                    cnt_in           = cnt_arr[gnt_idx];
                end
            end
            ST_WAIT: begin
                busy  = 1'b1;
                owner = owner_reg;
                // WAIT is only entered after a load, so cnt_done here always
                // reflects the owner's count.
                if (cnt_done) begin
                    resp_val[owner_reg] = 1'b1;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_count_timer_arb.sv
// -----------------------------------------------------------------------------
// tb_seq_count_timer_arb
//
// Directed bench for seq_count_timer_arb with a behavioural model of the
// shared down-counter (load, decrement to zero, hold; not reset by reset_n).
// Inputs change at posedge+1, outputs are sampled shortly after.
// -----------------------------------------------------------------------------
module tb_seq_count_timer_arb;

    localparam int NREQ = 4;
    localparam int W    = 3;
    localparam int OW   = 2;

    logic                clk      = 1'b0;
    logic                reset_n  = 1'b0;
    logic [NREQ-1:0]     req_val  = '0;
    logic [NREQ*W-1:0]   req_cnt  = '0;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ-1:0]     resp_val;
    logic                cnt_ld;
    logic [W-1:0]        cnt_in;
    logic                cnt_done;
    logic                busy;
    logic [OW-1:0]       owner;

    // Shared counter model
    logic [W-1:0]        cnt_q = '0;
    assign cnt_done = (cnt_q == '0);
    always @(posedge clk) begin
        if (cnt_ld)
            cnt_q <= cnt_in;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    always #5 clk = ~clk;

    seq_count_timer_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_cnt  (req_cnt),
        .req_rdy  (req_rdy),
        .resp_val (resp_val),
        .cnt_ld   (cnt_ld),
        .cnt_in   (cnt_in),
        .cnt_done (cnt_done),
        .busy     (busy),
        .owner    (owner)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [3:0] e_rdy, input logic [3:0] e_resp,
                              input logic e_ld, input logic [2:0] e_in,
                              input logic e_busy, input logic [1:0] e_owner);
        chk($sformatf("%s.req_rdy", tag),  32'(req_rdy),  32'(e_rdy));
        chk($sformatf("%s.resp_val", tag), 32'(resp_val), 32'(e_resp));
        chk($sformatf("%s.cnt_ld", tag),   32'(cnt_ld),   32'(e_ld));
        chk($sformatf("%s.cnt_in", tag),   32'(cnt_in),   32'(e_in));
        chk($sformatf("%s.busy", tag),     32'(busy),     32'(e_busy));
        chk($sformatf("%s.owner", tag),    32'(owner),    32'(e_owner));
        $display("[%0t] %s rdy=%b resp=%b ld=%b in=%0d busy=%b owner=%0d",
                 $time, tag, req_rdy, resp_val, cnt_ld, cnt_in, busy, owner);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset for one full cycle; returns at posedge+1 with reset released.
    task automatic apply_reset;
        reset_n = 1'b0;
        req_val = '0;
        tick();
        reset_n = 1'b1;
    endtask

    logic [3:0] one_hot;

    initial begin
        // ---------------- Reset state ----------------
        #3;
        expect_out("reset", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);
        tick();
        reset_n = 1'b1;

        // ---------------- Single request, count 3 ----------------
        req_val = 4'b0100;
        req_cnt = {3'd0, 3'd3, 3'd0, 3'd0};
        #1;
        expect_out("single.c0", 4'b0100, 4'b0000, 1'b1, 3'd3, 1'b0, 2'd0);
        tick();
        req_val = 4'b0000;
        #1;
        expect_out("single.c1", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd2);
        tick();
        expect_out("single.c2", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd2);
        tick();
        expect_out("single.c3", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd2);
        tick();
        expect_out("single.c4", 4'b0000, 4'b0100, 1'b0, 3'd0, 1'b1, 2'd2);
        tick();
        expect_out("single.c5", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);

        // ---------------- Zero count (ptr=3 scan reaches 1) ----------------
        req_val = 4'b0010;
        req_cnt = {3'd0, 3'd0, 3'd0, 3'd0};
        #1;
        expect_out("zero.c0", 4'b0010, 4'b0000, 1'b1, 3'd0, 1'b0, 2'd0);
        tick();
        req_val = 4'b0000;
        #1;
        expect_out("zero.c1", 4'b0000, 4'b0010, 1'b0, 3'd0, 1'b1, 2'd1);
        tick();
        expect_out("zero.c2", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);

        // ---------------- Round robin, all requesting, counts 1 ----------------
        apply_reset();
        req_val = 4'b1111;
        req_cnt = {3'd1, 3'd1, 3'd1, 3'd1};
        #1;
        for (int r = 0; r < 5; r++) begin
            one_hot = 4'b0001 << (r % 4);
            expect_out($sformatf("rr%0d.grant", r), one_hot, 4'b0000, 1'b1, 3'd1, 1'b0, 2'd0);
            tick();
            expect_out($sformatf("rr%0d.wait", r), 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'(r % 4));
            tick();
            expect_out($sformatf("rr%0d.resp", r), 4'b0000, one_hot, 1'b0, 3'd0, 1'b1, 2'(r % 4));
            tick();
        end

        // ---------------- Fairness: 0 and 3 both held ----------------
        apply_reset();
        req_val = 4'b1001;
        req_cnt = {3'd0, 3'd0, 3'd0, 3'd0};
        #1;
        expect_out("fair.g0", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0, 2'd0);
        tick();
        expect_out("fair.r0", 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        expect_out("fair.g1", 4'b1000, 4'b0000, 1'b1, 3'd0, 1'b0, 2'd0);
        tick();
        expect_out("fair.r1", 4'b0000, 4'b1000, 1'b0, 3'd0, 1'b1, 2'd3);
        tick();
        expect_out("fair.g2", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0, 2'd0);
        tick();
        expect_out("fair.r2", 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        expect_out("fair.g3", 4'b1000, 4'b0000, 1'b1, 3'd0, 1'b0, 2'd0);

        // ---------------- Reset mid-operation ----------------
        apply_reset();
        req_val = 4'b0010;
        req_cnt = {3'd0, 3'd0, 3'd7, 3'd0};
        #1;
        expect_out("rstmid.c0", 4'b0010, 4'b0000, 1'b1, 3'd7, 1'b0, 2'd0);
        tick();
        req_val = 4'b0000;
        #1;
        expect_out("rstmid.c1", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        expect_out("rstmid.async", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_out($sformatf("rstmid.hold%0d", k), 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);
        end
        reset_n = 1'b1;
        req_val = 4'b0010;
        #1;
        expect_out("rstmid.regrant", 4'b0010, 4'b0000, 1'b1, 3'd7, 1'b0, 2'd0);
        tick();
        req_val = 4'b0000;
        #1;
        for (int k = 1; k < 8; k++) begin
            expect_out($sformatf("rstmid.wait%0d", k), 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd1);
            tick();
        end
        expect_out("rstmid.resp", 4'b0000, 4'b0010, 1'b0, 3'd0, 1'b1, 2'd1);
        tick();
        expect_out("rstmid.idle", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);

        // ---------------- Late requests ignored during WAIT ----------------
        apply_reset();
        req_val = 4'b0001;
        req_cnt = {3'd0, 3'd5, 3'd0, 3'd3};
        #1;
        expect_out("late.c0", 4'b0001, 4'b0000, 1'b1, 3'd3, 1'b0, 2'd0);
        tick();
        req_val = 4'b0100;
        #1;
        expect_out("late.c1", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        req_val = 4'b0000;
        #1;
        expect_out("late.c2", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        expect_out("late.c3", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        expect_out("late.c4", 4'b0000, 4'b0001, 1'b0, 3'd0, 1'b1, 2'd0);
        tick();
        expect_out("late.c5", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);
        tick();
        expect_out("late.c6", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
